// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the tick scheduler.
package tick_sched_pkg;

    // Per-channel timer state.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } ch_state_e;

    // Channel mode encoding.
    localparam logic ModeOneShot  = 1'b0;
    localparam logic ModePeriodic = 1'b1;

    // 100 ms tick at a 50 MHz system clock.
    localparam int unsigned TickMaxDefault = 32'd4_999_999;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a registered one-cycle tick every TICK_MAX+1 cycles.
module tick_gen
    import tick_sched_pkg::*;
#(
    parameter int unsigned TICK_MAX = TickMaxDefault
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic tick
);

    localparam int unsigned CntW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_MAX);

    logic [CntW-1:0] cnt_q;
    logic            tick_q;
    logic            wrap;

    assign wrap = (cnt_q == CntMax);
    assign tick = tick_q;

    // Count 0..TICK_MAX, wrap to 0, and register the terminal-count pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= wrap ? '0 : cnt_q + 1'b1;
            tick_q <= wrap;
        end
    end

endmodule

// File: rtl/tick_sched.sv
// Multi-channel tick timer with round-robin expiry event arbitration.
module tick_sched
    import tick_sched_pkg::*;
#(
    parameter  int unsigned TICK_MAX = TickMaxDefault,
    parameter  int unsigned NUM_CH   = 4,
    parameter  int unsigned PERIOD_W = 8,
    localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cfg_wr,
    input  logic [ChW-1:0]      cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_mode,
    input  logic [NUM_CH-1:0]   start,
    input  logic [NUM_CH-1:0]   stop,
    output logic                evt_valid,
    output logic [ChW-1:0]      evt_ch,
    input  logic                evt_ready,
    output logic [NUM_CH-1:0]   ch_busy,
    output logic [NUM_CH-1:0]   overrun,
    output logic                tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clr;
    logic              hs;
    logic              evt_valid_q, evt_valid_d;
    logic [ChW-1:0]    evt_ch_q, evt_ch_d;
    logic [ChW-1:0]    ptr_q, ptr_d;
    logic [ChW-1:0]    idx;
    logic              found;

    tick_gen #(
        .TICK_MAX (TICK_MAX)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick    (tick)
    );

    assign hs = evt_valid_q && evt_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_e           state_q, state_d;
        logic [PERIOD_W-1:0] cnt_q, cnt_d;
        logic [PERIOD_W-1:0] period_q;
        logic                mode_q;
        logic                expire;
        logic                busy;
        logic                pend_q;
        logic                ovr_q;
        logic                cfg_hit;

        assign cfg_hit = cfg_wr && (cfg_ch == ChW'(g));
        assign clr[g]  = hs && (evt_ch_q == ChW'(g));

        // State, counter and configuration registers.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state_q  <= StIdle;
                cnt_q    <= '0;
                period_q <= '0;
                mode_q   <= ModeOneShot;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (cfg_hit) begin
                    period_q <= cfg_period;
                    mode_q   <= cfg_mode;
                end
            end
        end

        // Next state: stop beats start, start beats counting.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            expire  = 1'b0;
            if (stop[g]) begin
                state_d = StIdle;
            end else if (start[g] && (period_q != '0)) begin
                state_d = StRun;
                cnt_d   = period_q;
            end else if ((state_q == StRun) && tick) begin
                if (cnt_q == PERIOD_W'(1)) begin
                    expire = 1'b1;
                    if (mode_q == ModePeriodic) begin
                        cnt_d = period_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q > PERIOD_W'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end

        // Outputs decoded from the state.
        always_comb begin
            busy = (state_q == StRun);
        end

        // Pending/overrun: an expiry racing its own handshake is not an overrun.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                if (cfg_hit) begin
                    ovr_q <= 1'b0;
                end
                if (expire) begin
                    pend_q <= 1'b1;
                    if (pend_q && !clr[g]) begin
                        ovr_q <= 1'b1;
                    end
                end else if (clr[g]) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign ch_busy[g] = busy;
        assign pending[g] = pend_q;
        assign overrun[g] = ovr_q;
    end

    // Arbiter next state: hold while stalled, idle one cycle after each handshake.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        ptr_d       = ptr_q;
        idx         = '0;
        found       = 1'b0;
        if (evt_valid_q) begin
            if (evt_ready) begin
                evt_valid_d = 1'b0;
                ptr_d       = (evt_ch_q == ChW'(NUM_CH - 1)) ? '0 : evt_ch_q + 1'b1;
            end
        end else if (|pending) begin
            evt_valid_d = 1'b1;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = ChW'((32'(ptr_q) + k) % NUM_CH);
                if (!found && pending[idx]) begin
                    found    = 1'b1;
                    evt_ch_d = idx;
                end
            end
        end
    end

    // Arbiter registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;

endmodule

// File: tb/tb_tick_sched.sv
// Self-checking bench for tick_sched: directed scenarios plus random traffic vs a reference model.
module tb_tick_sched;

    localparam int unsigned TM = 9;
    localparam int unsigned NC = 4;
    localparam int unsigned PW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          cfg_wr;
    logic [1:0]    cfg_ch;
    logic [PW-1:0] cfg_period;
    logic          cfg_mode;
    logic [NC-1:0] start;
    logic [NC-1:0] stop;
    logic          evt_valid;
    logic [1:0]    evt_ch;
    logic          evt_ready;
    logic [NC-1:0] ch_busy;
    logic [NC-1:0] overrun;
    logic          tick;

    tick_sched #(
        .TICK_MAX (TM),
        .NUM_CH   (NC),
        .PERIOD_W (PW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_ready  (evt_ready),
        .ch_busy    (ch_busy),
        .overrun    (overrun),
        .tick       (tick)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: timing expressed as edges since reset and ticks remaining per channel.
    int cyc;
    bit m_tick;
    bit m_valid;
    int m_ch;
    int m_ptr;
    bit m_run [NC];
    int m_left[NC];
    int m_per [NC];
    bit m_mode[NC];
    bit m_pend[NC];
    bit m_ovr [NC];

    int n_evt[NC];
    int hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] pack(input bit v[NC]);
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_update();
        bit old_pend[NC];
        bit m_hs;
        int hs_ch;
        bit exp_i;
        bit clr_i;
        if (sys_rst) begin
            cyc = 0; m_tick = 0; m_valid = 0; m_ch = 0; m_ptr = 0;
            for (int i = 0; i < NC; i++) begin
                m_run[i] = 0; m_left[i] = 0; m_per[i] = 0;
                m_mode[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
            end
            return;
        end
        m_hs     = m_valid && evt_ready;
        hs_ch    = m_ch;
        old_pend = m_pend;
        for (int i = 0; i < NC; i++) begin
            exp_i = 0;
            if (stop[i]) begin
                m_run[i] = 0;
            end else if (start[i] && m_per[i] != 0) begin
                m_run[i]  = 1;
                m_left[i] = m_per[i];
            end else if (m_run[i] && m_tick) begin
                if (m_left[i] == 1) begin
                    exp_i = 1;
                    if (m_mode[i]) m_left[i] = m_per[i];
                    else m_run[i] = 0;
                end else if (m_left[i] > 1) begin
                    m_left[i]--;
                end
            end
            if (cfg_wr && int'(cfg_ch) == i) begin
                m_per[i]  = int'(cfg_period);
                m_mode[i] = cfg_mode;
                m_ovr[i]  = 0;
            end
            clr_i = m_hs && hs_ch == i;
            if (exp_i) begin
                if (old_pend[i] && !clr_i) m_ovr[i] = 1;
                m_pend[i] = 1;
            end else if (clr_i) begin
                m_pend[i] = 0;
            end
        end
        if (m_valid) begin
            if (evt_ready) begin
                m_valid = 0;
                m_ptr   = (m_ch + 1) % NC;
            end
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (!m_valid && old_pend[(m_ptr + k) % NC]) begin
                    m_valid = 1;
                    m_ch    = (m_ptr + k) % NC;
                end
            end
        end
        cyc++;
        m_tick = (cyc % (TM + 1) == 0);
    endtask

    task automatic step();
        bit hs_dut;
        int hs_ch;
        hs_dut = evt_valid && evt_ready;
        hs_ch  = int'(evt_ch);
        @(posedge sys_clk);
        model_update();
        if (hs_dut) begin
            n_evt[hs_ch]++;
            hist.push_back(hs_ch);
        end
        #1;
        check("tick", 32'(tick), 32'(m_tick));
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        check("evt_ch", 32'(evt_ch), 32'(m_ch));
        check("ch_busy", 32'(ch_busy), 32'(pack(m_run)));
        check("overrun", 32'(overrun), 32'(pack(m_ovr)));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int ch, input int per, input bit mode);
        cfg_wr = 1; cfg_ch = 2'(ch); cfg_period = PW'(per); cfg_mode = mode;
        step();
        cfg_wr = 0;
    endtask

    task automatic pulse(input logic [NC-1:0] s, input logic [NC-1:0] p);
        start = s; stop = p;
        step();
        start = '0; stop = '0;
    endtask

    initial begin
        int n0;
        int ntot;
        sys_rst = 1; cfg_wr = 0; cfg_ch = '0; cfg_period = '0; cfg_mode = 0;
        start = '0; stop = '0; evt_ready = 0;
        for (int i = 0; i < NC; i++) n_evt[i] = 0;
        steps(3);
        sys_rst = 0;

        // Idle after reset: ticks on cycles 10, 20, 30 only.
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k % 10 == 0) check("tick_period", 32'(tick), 32'd1);
        end
        check("idle_valid", 32'(evt_valid), 32'd0);
        check("idle_busy", 32'(ch_busy), 32'd0);

        // One-shot ch0, period 3.
        evt_ready = 1;
        cfg(0, 3, 1'b0);
        pulse(4'b0001, 4'b0000);
        steps(45);
        check("oneshot_events", 32'(n_evt[0]), 32'd1);
        check("oneshot_busy", 32'(ch_busy[0]), 32'd0);
        steps(25);
        check("oneshot_single", 32'(n_evt[0]), 32'd1);

        // Ch1 and ch2 periodic, period 1, alternating events.
        hist.delete();
        cfg(1, 1, 1'b1);
        cfg(2, 1, 1'b1);
        pulse(4'b0110, 4'b0000);
        steps(45);
        check("alt_count", 32'(hist.size() >= 4), 32'd1);
        if (hist.size() >= 4) begin
            check("alt_0", 32'(hist[0]), 32'd1);
            check("alt_1", 32'(hist[1]), 32'd2);
            check("alt_2", 32'(hist[2]), 32'd1);
            check("alt_3", 32'(hist[3]), 32'd2);
        end
        check("alt_overrun", 32'(overrun), 32'd0);
        pulse(4'b0000, 4'b0110);
        steps(10);

        // Ch3 stalled consumer -> held event and overrun, cleared by cfg_wr.
        evt_ready = 0;
        cfg(3, 1, 1'b1);
        pulse(4'b1000, 4'b0000);
        steps(35);
        check("stall_valid", 32'(evt_valid), 32'd1);
        check("stall_ch", 32'(evt_ch), 32'd3);
        check("stall_overrun", 32'(overrun[3]), 32'd1);
        while (m_tick) step();
        cfg(3, 1, 1'b1);
        check("cfg_clears_overrun", 32'(overrun[3]), 32'd0);
        pulse(4'b0000, 4'b1000);
        evt_ready = 1;
        steps(10);

        // Start and stop together on ch0: stop wins.
        n0 = n_evt[0];
        pulse(4'b0001, 4'b0001);
        check("startstop_busy", 32'(ch_busy[0]), 32'd0);
        steps(40);
        check("startstop_noevt", 32'(n_evt[0]), 32'(n0));

        // Reset mid-count on ch2.
        cfg(2, 4, 1'b1);
        pulse(4'b0100, 4'b0000);
        steps(15);
        check("pre_rst_busy", 32'(ch_busy[2]), 32'd1);
        sys_rst = 1;
        step();
        sys_rst = 0;
        check("rst_busy", 32'(ch_busy), 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_ch", 32'(evt_ch), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        ntot = hist.size();
        steps(60);
        check("rst_no_event", 32'(hist.size()), 32'(ntot));
        // Period cleared by reset, so a start is ignored.
        pulse(4'b0010, 4'b0000);
        check("zero_period_start", 32'(ch_busy[1]), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 2500; k++) begin
            cfg_wr     = !m_tick && ($urandom_range(0, 11) == 0);
            cfg_ch     = 2'($urandom_range(0, NC - 1));
            cfg_period = PW'($urandom_range(1, 5));
            cfg_mode   = 1'($urandom_range(0, 1));
            for (int i = 0; i < NC; i++) begin
                start[i] = !m_tick && ($urandom_range(0, 19) == 0);
                stop[i]  = ($urandom_range(0, 39) == 0);
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cfg_wr = 0; start = '0; stop = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
